// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, stalls,
// multi-cycle unit scoreboard and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int RA_W       = 5,
  parameter int MC_LATENCY = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   d_rs,
  input  logic [RA_W-1:0]   d_rt,
  input  logic              d_branch,
  input  logic              d_mc_op,
  input  logic [RA_W-1:0]   e_rs,
  input  logic [RA_W-1:0]   e_rt,
  input  logic [RA_W-1:0]   e_rf_wa,
  input  logic              e_rf_we,
  input  logic              e_is_load,
  input  logic              e_mc_issue,
  input  logic [RA_W-1:0]   m_rf_wa,
  input  logic [RA_W-1:0]   w_rf_wa,
  input  logic              m_rf_we,
  input  logic              w_rf_we,
  input  logic              m_is_load,
  output logic [1:0]        sel_forward_alu_a,
  output logic [1:0]        sel_forward_alu_b,
  output logic              d_fwd_a,
  output logic              d_fwd_b,
  output logic              f_stall,
  output logic              d_stall,
  output logic              e_flush,
  output logic              mc_busy,
  output logic              mc_wb_valid,
  output logic [RA_W-1:0]   mc_wb_wa,
  output logic              mc_err,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LAT = CW'(MC_LATENCY);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic {
    IDLE,
    BUSY
  } mc_state_e;

  mc_state_e         state_q;
  mc_state_e         state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [RA_W-1:0]   wa_q;
  logic [RA_W-1:0]   wa_d;
  logic              valid_q;
  logic              valid_d;
  logic              err_q;
  logic              err_d;
  logic [PERF_W-1:0] perf_q;

  logic a_m, a_w, b_m, b_w;
  logic hit_e, hit_m, hit_mc;
  logic load_use, br_e, br_m;
  logic mc_raw, mc_struct, stall;

  always_comb begin
    a_m = (e_rs != '0) && (e_rs == m_rf_wa) && m_rf_we;
    a_w = (e_rs != '0) && (e_rs == w_rf_wa) && w_rf_we;
    b_m = (e_rt != '0) && (e_rt == m_rf_wa) && m_rf_we;
    b_w = (e_rt != '0) && (e_rt == w_rf_wa) && w_rf_we;
  end

  // M is the younger producer, so it wins over W
  always_comb begin
    sel_forward_alu_a = 2'b00;
    priority case (1'b1)
      a_m:     sel_forward_alu_a = 2'b10;
      a_w:     sel_forward_alu_a = 2'b01;
      default: sel_forward_alu_a = 2'b00;
    endcase
  end

  always_comb begin
    sel_forward_alu_b = 2'b00;
    priority case (1'b1)
      b_m:     sel_forward_alu_b = 2'b10;
      b_w:     sel_forward_alu_b = 2'b01;
      default: sel_forward_alu_b = 2'b00;
    endcase
  end

  always_comb begin
    d_fwd_a = d_branch && (d_rs != '0) && (d_rs == m_rf_wa)
              && m_rf_we && !m_is_load;
    d_fwd_b = d_branch && (d_rt != '0) && (d_rt == m_rf_wa)
              && m_rf_we && !m_is_load;
  end

  always_comb begin
    hit_e  = (e_rf_wa != '0)
             && ((d_rs == e_rf_wa) || (d_rt == e_rf_wa));
    hit_m  = (m_rf_wa != '0)
             && ((d_rs == m_rf_wa) || (d_rt == m_rf_wa));
    hit_mc = (wa_q != '0)
             && ((d_rs == wa_q) || (d_rt == wa_q));
  end

  always_comb begin
    load_use  = e_is_load && hit_e;
    br_e      = d_branch && e_rf_we && hit_e;
    br_m      = d_branch && m_is_load && hit_m;
    mc_raw    = mc_busy && hit_mc;
    mc_struct = d_mc_op && mc_busy && (cnt_q > ONE);
    stall     = load_use | br_e | br_m | mc_raw | mc_struct;
  end

  assign f_stall = stall;
  assign d_stall = stall;
  assign e_flush = stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (e_mc_issue) begin
          state_d = BUSY;
          cnt_d   = LAT;
          wa_d    = e_rf_wa;
        end
      end
      BUSY: begin
        if (cnt_q == ONE) begin
          // last busy cycle: a new issue may chain straight on
          if (e_mc_issue) begin
            cnt_d = LAT;
            wa_d  = e_rf_wa;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
          if (e_mc_issue) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    valid_d = (state_d == BUSY) && (cnt_d == ONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wa_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      if (stall && (perf_q != '1)) begin
        perf_q <= perf_q + 1'b1;
      end
    end
  end

  assign mc_busy      = (state_q == BUSY);
  assign mc_wb_valid  = valid_q;
  assign mc_wb_wa     = wa_q;
  assign mc_err       = err_q;
  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed
// multi-cycle sequences and random stimulus against a timeline model.
module tb_hazard_scoreboard;

  localparam int LAT    = 4;
  localparam int PW     = 8;
  localparam int SATMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa;
  logic d_branch, d_mc_op, e_rf_we, e_is_load, e_mc_issue;
  logic m_rf_we, w_rf_we, m_is_load;
  logic [1:0] sel_forward_alu_a, sel_forward_alu_b;
  logic d_fwd_a, d_fwd_b, f_stall, d_stall, e_flush;
  logic mc_busy, mc_wb_valid, mc_err;
  logic [4:0] mc_wb_wa;
  logic [PW-1:0] stall_cycles;

  hazard_scoreboard #(
    .RA_W(5), .MC_LATENCY(LAT), .PERF_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_branch(d_branch), .d_mc_op(d_mc_op),
    .e_rs(e_rs), .e_rt(e_rt), .e_rf_wa(e_rf_wa), .e_rf_we(e_rf_we),
    .e_is_load(e_is_load), .e_mc_issue(e_mc_issue),
    .m_rf_wa(m_rf_wa), .w_rf_wa(w_rf_wa), .m_rf_we(m_rf_we),
    .w_rf_we(w_rf_we), .m_is_load(m_is_load),
    .sel_forward_alu_a(sel_forward_alu_a),
    .sel_forward_alu_b(sel_forward_alu_b),
    .d_fwd_a(d_fwd_a), .d_fwd_b(d_fwd_b),
    .f_stall(f_stall), .d_stall(d_stall), .e_flush(e_flush),
    .mc_busy(mc_busy), .mc_wb_valid(mc_wb_valid), .mc_wb_wa(mc_wb_wa),
    .mc_err(mc_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_rf_wa, m_rf_wa, w_rf_wa;
    logic d_branch, e_rf_we, e_is_load, m_rf_we, w_rf_we, m_is_load;
    logic [1:0] fa, fb;
    logic dfa, dfb, stall;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // model: op in flight owns cycles (issue, wb_t], writeback at wb_t
  int t;
  bit m_have;
  int m_wb_t;
  logic [4:0] m_wa;
  bit m_err;
  int m_sc;
  bit last_stall;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic idle_inputs();
    d_rs = 0; d_rt = 0; e_rs = 0; e_rt = 0; e_rf_wa = 0;
    m_rf_wa = 0; w_rf_wa = 0; d_branch = 0; d_mc_op = 0;
    e_rf_we = 0; e_is_load = 0; e_mc_issue = 0;
    m_rf_we = 0; w_rf_we = 0; m_is_load = 0;
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] r);
    if (r != 0 && r == m_rf_wa && m_rf_we) return 2'b10;
    if (r != 0 && r == w_rf_wa && w_rf_we) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 0 && (d_rs == r || d_rt == r);
  endfunction

  task automatic check_model();
    bit st;
    st = (e_is_load && reads(e_rf_wa))
      || (d_branch && e_rf_we && reads(e_rf_wa))
      || (d_branch && m_is_load && reads(m_rf_wa))
      || (m_have && reads(m_wa))
      || (d_mc_op && m_have && t < m_wb_t);
    last_stall = st;
    chk("fwd_a", sel_forward_alu_a, fwd_sel(e_rs));
    chk("fwd_b", sel_forward_alu_b, fwd_sel(e_rt));
    chk("d_fwd_a", d_fwd_a, d_branch && d_rs != 0 && d_rs == m_rf_wa
        && m_rf_we && !m_is_load);
    chk("d_fwd_b", d_fwd_b, d_branch && d_rt != 0 && d_rt == m_rf_wa
        && m_rf_we && !m_is_load);
    chk("stall", {f_stall, d_stall, e_flush}, st ? 3'b111 : 3'b000);
    chk("mc_busy", mc_busy, m_have);
    chk("mc_wb_valid", mc_wb_valid, m_have && t == m_wb_t);
    chk("mc_wb_wa", mc_wb_wa, m_wa);
    chk("mc_err", mc_err, m_err);
    chk("stall_cycles", stall_cycles, m_sc);
  endtask

  task automatic sample();
    #4;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_have = 0; m_wa = 0; m_err = 0; m_sc = 0;
    end else begin
      if (e_mc_issue) begin
        if (!m_have || t == m_wb_t) begin
          m_have = 1; m_wb_t = t + LAT; m_wa = e_rf_wa;
        end else begin
          m_err = 1;
        end
      end else if (m_have && t == m_wb_t) begin
        m_have = 0;
      end
      if (last_stall && m_sc < SATMAX) m_sc++;
    end
    t++;
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1;
    m_have = 0; m_wa = 0; m_err = 0; m_sc = 0; t = 0;
  endtask

  task automatic drive(input vec_t v);
    idle_inputs();
    d_rs = v.d_rs; d_rt = v.d_rt; e_rs = v.e_rs; e_rt = v.e_rt;
    e_rf_wa = v.e_rf_wa; m_rf_wa = v.m_rf_wa; w_rf_wa = v.w_rf_wa;
    d_branch = v.d_branch; e_rf_we = v.e_rf_we;
    e_is_load = v.e_is_load; m_rf_we = v.m_rf_we;
    w_rf_we = v.w_rf_we; m_is_load = v.m_is_load;
  endtask

  vec_t tv[$];

  initial begin
    vec_t b, v;
    b = '{d_rs:0, d_rt:0, e_rs:0, e_rt:0, e_rf_wa:0, m_rf_wa:0,
          w_rf_wa:0, d_branch:0, e_rf_we:0, e_is_load:0, m_rf_we:0,
          w_rf_we:0, m_is_load:0, fa:0, fb:0, dfa:0, dfb:0, stall:0};
    v = b; v.e_is_load = 1; v.e_rf_we = 1; v.e_rf_wa = 8; v.d_rs = 8;
    v.stall = 1; tv.push_back(v);
    v = b; v.e_is_load = 1; v.e_rf_we = 1; tv.push_back(v);
    v = b; v.e_rs = 5; v.m_rf_wa = 5; v.m_rf_we = 1; v.w_rf_wa = 5;
    v.w_rf_we = 1; v.fa = 2'b10; tv.push_back(v);
    v = b; v.e_rs = 5; v.m_rf_wa = 5; v.w_rf_wa = 5; v.w_rf_we = 1;
    v.fa = 2'b01; tv.push_back(v);
    v = b; v.m_rf_we = 1; v.w_rf_we = 1; tv.push_back(v);
    v = b; v.e_rt = 7; v.w_rf_wa = 7; v.w_rf_we = 1; v.m_rf_wa = 3;
    v.m_rf_we = 1; v.fb = 2'b01; tv.push_back(v);
    v = b; v.d_branch = 1; v.d_rs = 9; v.e_rf_wa = 9; v.e_rf_we = 1;
    v.stall = 1; tv.push_back(v);
    v = b; v.d_branch = 1; v.d_rs = 9; v.m_rf_wa = 9; v.m_rf_we = 1;
    v.dfa = 1; tv.push_back(v);
    v = b; v.d_branch = 1; v.d_rs = 9; v.m_rf_wa = 9; v.m_rf_we = 1;
    v.m_is_load = 1; v.stall = 1; tv.push_back(v);
    v = b; v.d_branch = 1; v.d_rt = 4; v.m_rf_wa = 4; v.m_rf_we = 1;
    v.dfb = 1; tv.push_back(v);
    v = b; v.d_rs = 9; v.e_rf_wa = 9; v.e_rf_we = 1; tv.push_back(v);

    do_reset();
    #4;
    chk("rst_busy", mc_busy, 0);
    chk("rst_valid", mc_wb_valid, 0);
    chk("rst_wa", mc_wb_wa, 0);
    chk("rst_err", mc_err, 0);
    chk("rst_perf", stall_cycles, 0);
    tick();

    foreach (tv[i]) begin
      drive(tv[i]);
      sample();
      chk($sformatf("vec%0d_fa", i), sel_forward_alu_a, tv[i].fa);
      chk($sformatf("vec%0d_fb", i), sel_forward_alu_b, tv[i].fb);
      chk($sformatf("vec%0d_dfa", i), d_fwd_a, tv[i].dfa);
      chk($sformatf("vec%0d_dfb", i), d_fwd_b, tv[i].dfb);
      chk($sformatf("vec%0d_stall", i), f_stall, tv[i].stall);
      tick();
    end

    // latency: issue wa=12 at cycle 0, D reads $12 afterwards
    do_reset();
    e_mc_issue = 1; e_rf_wa = 12; e_rf_we = 1;
    step();
    idle_inputs(); d_rs = 12;
    for (int k = 1; k <= 5; k++) begin
      sample();
      chk("lat_busy", mc_busy, k <= 4);
      chk("lat_valid", mc_wb_valid, k == 4);
      chk("lat_stall", d_stall, k <= 4);
      if (k == 4) chk("lat_wa", mc_wb_wa, 12);
      tick();
    end

    // structural stall, back-to-back issue, illegal issue
    do_reset();
    e_mc_issue = 1; e_rf_wa = 3;
    step();
    idle_inputs();
    step();
    d_mc_op = 1;
    sample(); chk("struct_stall", d_stall, 1); tick();
    d_mc_op = 0;
    step();
    e_mc_issue = 1; e_rf_wa = 6;
    sample();
    chk("b2b_valid", mc_wb_valid, 1);
    chk("b2b_old_wa", mc_wb_wa, 3);
    tick();
    idle_inputs();
    sample();
    chk("b2b_busy", mc_busy, 1);
    chk("b2b_new_wa", mc_wb_wa, 6);
    chk("b2b_err", mc_err, 0);
    tick();
    e_mc_issue = 1; e_rf_wa = 9;
    step();
    idle_inputs();
    sample(); chk("err_set", mc_err, 1); tick();
    sample();
    chk("err_valid", mc_wb_valid, 1);
    chk("err_keep_wa", mc_wb_wa, 6);
    tick();
    sample();
    chk("err_idle", mc_busy, 0);
    chk("err_sticky", mc_err, 1);
    tick();

    // reset while count=2 abandons the op
    do_reset();
    d_rs = 8; e_is_load = 1; e_rf_wa = 8;
    step();
    idle_inputs();
    e_mc_issue = 1; e_rf_wa = 12;
    step();
    idle_inputs();
    step();
    step();
    reset = 0;
    step();
    reset = 1;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("rst_mc_busy", mc_busy, 0);
      chk("rst_mc_valid", mc_wb_valid, 0);
      chk("rst_mc_perf", stall_cycles, 0);
      tick();
    end

    // saturation
    do_reset();
    d_rs = 8; e_is_load = 1; e_rf_wa = 8;
    repeat ((1 << PW) + 3) step();
    sample();
    chk("perf_sat", stall_cycles, SATMAX);
    tick();

    do_reset();
    for (int k = 0; k < 600; k++) begin
      d_rs = 5'($urandom_range(0, 7)); d_rt = 5'($urandom_range(0, 7));
      e_rs = 5'($urandom_range(0, 7)); e_rt = 5'($urandom_range(0, 7));
      e_rf_wa = 5'($urandom_range(0, 7));
      m_rf_wa = 5'($urandom_range(0, 7));
      w_rf_wa = 5'($urandom_range(0, 7));
      d_branch = 1'($urandom_range(0, 1));
      d_mc_op = ($urandom_range(0, 3) == 0);
      e_rf_we = 1'($urandom_range(0, 1));
      e_is_load = ($urandom_range(0, 3) == 0);
      e_mc_issue = ($urandom_range(0, 5) == 0);
      m_rf_we = 1'($urandom_range(0, 1));
      w_rf_we = 1'($urandom_range(0, 1));
      m_is_load = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 99) != 0);
      step();
    end
    reset = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
